// File: rtl/uart_pkg.sv
// Shared definitions for the UART duty-cycle receiver: FSM states, sample
// points within a bit, and the baud divider calculation.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rx_state_t;

   // Sample-counter value at which a bit is sampled: half a bit into the start
   // bit, then one full bit after the previous sample.
   localparam int MID_START = 7;
   localparam int MID_BIT   = 15;

   function automatic int calc_div(input int clk_hz, input int baud, input int oversample);
      return clk_hz / (baud * oversample);
   endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running oversample tick divider; clr realigns the tick phase to the
// detected start edge.
module baud_tick_gen #(
   parameter int DIV = 65
) (
   input  logic clk,
   input  logic rst_i,
   input  logic clr,
   output logic tick
);

   localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         cnt <= '0;
      end else if (clr || (cnt == LAST)) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   assign tick = (cnt == LAST) && !clr;

endmodule

// File: rtl/uart_duty_rx.sv
// 8N1 UART receiver whose last correctly framed byte is held on duty_o as the
// duty-cycle setting for the downstream PWM stage.
module uart_duty_rx
   import uart_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int CLK_HZ     = 10000000,
   parameter int BAUD       = 9600,
   parameter int OVERSAMPLE = 16
) (
   input  logic             clk,
   input  logic             rst_i,
   input  logic             rx_i,
   output logic [WIDTH-1:0] duty_o,
   output logic             duty_valid_o,
   output logic             frame_err_o,
   output logic             busy_o
);

   localparam int DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
   localparam int SW  = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam int IW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [SW-1:0] SMP_START = SW'(MID_START);
   localparam logic [SW-1:0] SMP_BIT   = SW'(MID_BIT);
   localparam logic [IW-1:0] LAST_BIT  = IW'(WIDTH - 1);

   // Synchroniser and edge-detect flops reset to the idle line level so that
   // leaving reset never looks like a start edge.
   logic sync_meta;
   logic sync_rx;
   logic sync_prev;
   logic rx_fall;

   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         sync_meta <= 1'b1;
         sync_rx   <= 1'b1;
         sync_prev <= 1'b1;
      end else begin
         sync_meta <= rx_i;
         sync_rx   <= sync_meta;
         sync_prev <= sync_rx;
      end
   end

   assign rx_fall = sync_prev & ~sync_rx;

   logic tick;
   logic tick_clr;

   baud_tick_gen #(
      .DIV (DIV)
   ) u_tick (
      .clk   (clk),
      .rst_i (rst_i),
      .clr   (tick_clr),
      .tick  (tick)
   );

   rx_state_t        state,    state_n;
   logic [SW-1:0]    smp_cnt,  smp_cnt_n;
   logic [IW-1:0]    bit_idx,  bit_idx_n;
   logic [WIDTH-1:0] shift,    shift_n;
   logic [WIDTH-1:0] duty,     duty_n;
   logic             valid,    valid_n;
   logic             ferr,     ferr_n;

   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         state   <= IDLE;
         smp_cnt <= '0;
         bit_idx <= '0;
         shift   <= '0;
         duty    <= '0;
         valid   <= 1'b0;
         ferr    <= 1'b0;
      end else begin
         state   <= state_n;
         smp_cnt <= smp_cnt_n;
         bit_idx <= bit_idx_n;
         shift   <= shift_n;
         duty    <= duty_n;
         valid   <= valid_n;
         ferr    <= ferr_n;
      end
   end

   always_comb begin
      state_n   = state;
      smp_cnt_n = smp_cnt;
      bit_idx_n = bit_idx;
      shift_n   = shift;
      duty_n    = duty;
      valid_n   = 1'b0;
      ferr_n    = ferr;
      tick_clr  = 1'b0;

      case (state)
         IDLE: begin
            if (rx_fall) begin
               state_n   = START;
               smp_cnt_n = '0;
               tick_clr  = 1'b1;
            end
         end

         START: begin
            if (tick) begin
               if (smp_cnt == SMP_START) begin
                  // A line already back high at mid-start was only a glitch.
                  if (!sync_rx) begin
                     state_n   = DATA;
                     smp_cnt_n = '0;
                     bit_idx_n = '0;
                  end else begin
                     state_n = IDLE;
                  end
               end else begin
                  smp_cnt_n = smp_cnt + SW'(1);
               end
            end
         end

         DATA: begin
            if (tick) begin
               if (smp_cnt == SMP_BIT) begin
                  shift_n   = {sync_rx, shift[WIDTH-1:1]};
                  smp_cnt_n = '0;
                  if (bit_idx == LAST_BIT) begin
                     state_n = STOP;
                  end else begin
                     bit_idx_n = bit_idx + IW'(1);
                  end
               end else begin
                  smp_cnt_n = smp_cnt + SW'(1);
               end
            end
         end

         STOP: begin
            if (tick) begin
               if (smp_cnt == SMP_BIT) begin
                  smp_cnt_n = '0;
                  state_n   = IDLE;
                  if (sync_rx) begin
                     duty_n  = shift;
                     valid_n = 1'b1;
                     ferr_n  = 1'b0;
                  end else begin
                     ferr_n = 1'b1;
                  end
               end else begin
                  smp_cnt_n = smp_cnt + SW'(1);
               end
            end
         end

         default: begin
            state_n = IDLE;
         end
      endcase
   end

   assign duty_o       = duty;
   assign duty_valid_o = valid;
   assign frame_err_o  = ferr;
   assign busy_o       = (state != IDLE);

endmodule

// File: tb/tb_uart_duty_rx.sv
// Directed bench for uart_duty_rx: frames are driven in real time at the stated
// baud rates, and a pulse-queue model checks duty_o on every clock.
module tb_uart_duty_rx;

   localparam int  WIDTH      = 8;
   // Clock chosen so the baud divider is exact (16) and frames stay short.
   localparam int  CLK_HZ     = 2457600;
   localparam int  BAUD       = 9600;
   localparam int  OVERSAMPLE = 16;
   localparam int  DIV        = CLK_HZ / (BAUD * OVERSAMPLE);
   localparam real CLK_HALF_NS = 1.0e9 / (2.0 * CLK_HZ);
   localparam real BIT_NOM    = 1.0e9 / 9600.0;
   localparam real BIT_SLOW   = 1.0e9 / 9408.0;
   localparam real BIT_FAST   = 1.0e9 / 9792.0;

   logic             clk   = 1'b0;
   logic             rst_i = 1'b0;
   logic             rx_i  = 1'b1;
   logic [WIDTH-1:0] duty_o;
   logic             duty_valid_o;
   logic             frame_err_o;
   logic             busy_o;

   int               checks = 0;
   int               errors = 0;
   logic [WIDTH-1:0] exp_q[$];
   logic [WIDTH-1:0] model_duty = '0;
   int               pulses     = 0;
   longint           cyc        = 0;
   longint           start_cyc  = 0;
   longint           pulse_cyc  = 0;
   logic             prev_valid = 1'b0;

   uart_duty_rx #(
      .WIDTH      (WIDTH),
      .CLK_HZ     (CLK_HZ),
      .BAUD       (BAUD),
      .OVERSAMPLE (OVERSAMPLE)
   ) dut (
      .clk          (clk),
      .rst_i        (rst_i),
      .rx_i         (rx_i),
      .duty_o       (duty_o),
      .duty_valid_o (duty_valid_o),
      .frame_err_o  (frame_err_o),
      .busy_o       (busy_o)
   );

   // clock / cycle counter
   always #(CLK_HALF_NS * 1ns) clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // scoreboard: every pulse must match the oldest expected byte, and duty_o
   // must hold the last accepted byte on every other cycle
   always @(negedge clk) begin
      if (rst_i) begin
         model_duty = '0;
         check("rst_duty", duty_o, 0);
         check("rst_valid", duty_valid_o, 0);
         check("rst_busy", busy_o, 0);
         check("rst_ferr", frame_err_o, 0);
      end else if (duty_valid_o) begin
         check("valid_one_cycle", prev_valid, 0);
         check("pulse_expected", exp_q.size() > 0, 1);
         if (exp_q.size() > 0) begin
            model_duty = exp_q.pop_front();
            check("pulse_duty", duty_o, model_duty);
            pulses++;
            pulse_cyc = cyc;
         end
      end else begin
         check("duty_hold", duty_o, model_duty);
      end
      prev_valid = duty_valid_o;
   end

   // driver: start bit, WIDTH data bits LSB first, stop bit at the given level
   task automatic send_frame(input logic [WIDTH-1:0] data, input logic stop_bit,
                             input real bit_ns, input bit expect_pulse);
      if (stop_bit && expect_pulse) exp_q.push_back(data);
      rx_i      = 1'b0;
      start_cyc = cyc;
      #(bit_ns * 1ns);
      for (int i = 0; i < WIDTH; i++) begin
         rx_i = data[i];
         #(bit_ns * 1ns);
      end
      rx_i = stop_bit;
      #(bit_ns * 1ns);
      rx_i = 1'b1;
   endtask

   task automatic settle(input string name);
      int n;
      n = 0;
      while (busy_o && n < 4000) begin
         @(negedge clk);
         n++;
      end
      check({name, "_idle"}, busy_o, 0);
      repeat (4) @(negedge clk);
      check({name, "_pending"}, exp_q.size(), 0);
   endtask

   initial begin
      #(5000ms);
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1, "watchdog expired");
   end

   initial begin
      longint lat;
      #(10ns);
      rst_i = 1'b1;
      rx_i  = 1'b1;
      repeat (5) @(negedge clk);
      check("reset_duty", duty_o, 8'h00);
      check("reset_valid", duty_valid_o, 0);
      check("reset_ferr", frame_err_o, 0);
      check("reset_busy", busy_o, 0);
      rst_i = 1'b0;
      repeat (20) @(negedge clk);

      // good frame; start edge to pulse = 3 sync + 128 start + 9*256 bits
      fork
         send_frame(8'h80, 1'b1, BIT_NOM, 1'b1);
         begin
            #(3.0 * BIT_NOM * 1ns);
            check("busy_mid_frame", busy_o, 1);
         end
      join
      settle("f80");
      check("f80_duty", duty_o, 8'h80);
      check("f80_ferr", frame_err_o, 0);
      check("f80_pulses", pulses, 1);
      lat = pulse_cyc - start_cyc;
      checks++;
      if (lat < 2425 || lat > 2445) begin
         errors++;
         $display("FAIL f80_latency: got %0d cycles expected 2425..2445", lat);
      end

      // glitch shorter than half a bit
      rx_i = 1'b0;
      #(3.0 * DIV * 2.0 * CLK_HALF_NS * 1ns);
      check("glitch_busy", busy_o, 1);
      rx_i = 1'b1;
      #(BIT_NOM * 1ns);
      check("glitch_idle", busy_o, 0);
      check("glitch_duty", duty_o, 8'h80);
      check("glitch_pulses", pulses, 1);

      // bad stop bit, then a good frame clears the error
      send_frame(8'h5A, 1'b0, BIT_NOM, 1'b1);
      settle("f5a");
      check("f5a_ferr", frame_err_o, 1);
      check("f5a_duty", duty_o, 8'h80);
      check("f5a_pulses", pulses, 1);

      send_frame(8'h33, 1'b1, BIT_NOM, 1'b1);
      settle("f33");
      check("f33_duty", duty_o, 8'h33);
      check("f33_ferr", frame_err_o, 0);
      check("f33_pulses", pulses, 2);

      // back-to-back at -2% and +2% baud
      send_frame(8'h00, 1'b1, BIT_SLOW, 1'b1);
      send_frame(8'hFF, 1'b1, BIT_SLOW, 1'b1);
      settle("slow");
      check("slow_duty", duty_o, 8'hFF);
      check("slow_pulses", pulses, 4);
      check("slow_ferr", frame_err_o, 0);

      send_frame(8'h00, 1'b1, BIT_FAST, 1'b1);
      send_frame(8'hFF, 1'b1, BIT_FAST, 1'b1);
      settle("fast");
      check("fast_duty", duty_o, 8'hFF);
      check("fast_pulses", pulses, 6);
      check("fast_ferr", frame_err_o, 0);

      // reset in the middle of data bit 4, held until the line is idle again
      fork
         send_frame(8'hC3, 1'b1, BIT_NOM, 1'b0);
         begin
            #(5.5 * BIT_NOM * 1ns);
            rst_i = 1'b1;
            repeat (2) @(negedge clk);
            check("midrst_duty", duty_o, 8'h00);
            check("midrst_busy", busy_o, 0);
            check("midrst_valid", duty_valid_o, 0);
            check("midrst_ferr", frame_err_o, 0);
         end
      join
      repeat (5) @(negedge clk);
      rst_i = 1'b0;
      repeat (20) @(negedge clk);

      send_frame(8'h10, 1'b1, BIT_NOM, 1'b1);
      settle("f10");
      check("f10_duty", duty_o, 8'h10);
      check("f10_ferr", frame_err_o, 0);
      check("f10_pulses", pulses, 7);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
